branch_seq: RTL and testbench
=============================

Name: branch_seq

Overview:
- Multi-cycle sequencer on the consumer side of the branch-condition flip-flop.
- On a decoded conditional branch (brzr/brnz/brpl/brmi), it drives the 2-bit condition select and the evaluate enable toward the condition evaluator, then registers the returned CON.
- If the branch is taken, it issues a PC load of PC + sign-extended offset.
- Sits between the control unit's instruction decode and the PC register; also keeps branch/taken statistics counters.

Parameters:
- DATA_W, 32, width of IR, PC and pc_next.
- OFF_W, 19, width of the IR branch-offset field C (IR[OFF_W-1:0]).
- CNT_W, 16, width of the saturating statistics counters.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request: IR holds a conditional branch; accepted only when busy=0.
- ir  input  DATA_W  instruction register; C2 = ir[20:19], C = ir[OFF_W-1:0].
- pc  input  DATA_W  current PC (already incremented past the branch), sampled with start.
- con  input  1  CON result from the condition evaluator; valid while con_en=1.
- c2  output  2  condition select to the evaluator: 00 zero, 01 nonzero, 10 positive, 11 negative.
- con_en  output  1  evaluate enable to the evaluator.
- con_q  output  1  registered CON of the most recent evaluation.
- pc_next  output  DATA_W  branch target.
- pc_load  output  1  one-cycle PC write strobe; asserted only when taken.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle completion pulse, taken or not.
- br_cnt  output  CNT_W  number of branches completed, saturating.
- taken_cnt  output  CNT_W  number of taken branches, saturating.

Behaviour:
- Reset (synchronous, active-high): the following are all 0.
  - State returns to IDLE.
  - Outputs c2, con_en, con_q, pc_next, pc_load, busy, done.
  - Both counters and the internal IR/PC latches.
  - Reset has priority over every other input, including mid-sequence: an in-flight branch is abandoned with no pc_load and no done.
- States: IDLE -> EVAL -> UPDATE -> IDLE. The state encoding comes from the package.
- IDLE:
  - busy=0, con_en=0.
  - start=1 at edge k: latch ir_l<=ir and pc_l<=pc; next state EVAL.
- EVAL (cycle k+1):
  - busy=1, con_en=1, c2=ir_l[20:19].
  - At the closing edge: con_q<=con; next state UPDATE.
- UPDATE (cycle k+2):
  - busy=1, done=1, pc_load=con_q.
  - pc_next = pc_l + sign-extended ir_l[OFF_W-1:0], computed modulo 2^DATA_W; wrap-around is silent.
  - At the closing edge: br_cnt += 1; taken_cnt += con_q; next state IDLE.
- Latency: start accepted at edge k -> done and pc_load asserted during cycle k+2. Throughput is one branch per 3 cycles.
- c2 is driven from ir_l in every state. pc_next is held between sequences; it is meaningful only while pc_load=1.
- start while busy=1 is ignored and not queued, including start during UPDATE. The next start is accepted in IDLE.
- con_q holds its value until the next EVAL completes.
- Counters saturate at 2^CNT_W-1 and never wrap. taken_cnt <= br_cnt always.
- con is sampled only at the end of EVAL; changes in other cycles have no effect.

Decomposition:
- Package branch_pkg:
  - State enum: IDLE, EVAL, UPDATE.
  - Condition codes: COND_ZR=2'b00, COND_NZ=2'b01, COND_PL=2'b10, COND_MI=2'b11.
  - Field constants: C2_HI=20, C2_LO=19, OFF_W default 19.
- Sub-module sat_counter (parameter W; inputs clock, reset, inc; output q), instantiated twice for br_cnt and taken_cnt.
- Sign extension and the adder stay inline.

Test Plan:
- Taken forward branch:
  - Stimulus: reset 2 cycles; pc=32'h0000_0100, ir C2=00, C=19'h00010; start 1 cycle; con=1 in EVAL.
  - Response: con_en=1 and c2=00 at k+1; at k+2 pc_load=1, pc_next=32'h0000_0110, done=1; br_cnt=1, taken_cnt=1.
- Not taken:
  - Stimulus: C2=01, con=0.
  - Response: done=1 at k+2, pc_load=0, con_q=0; br_cnt increments, taken_cnt unchanged.
- Negative offset with wrap:
  - Case 1: pc=32'h0000_0004, C=19'h7FFF8 (-8), con=1 -> pc_next=32'hFFFF_FFFC.
  - Case 2: pc=32'h0000_0100, C=19'h7FFF0 -> pc_next=32'h0000_00F0.
- start while busy:
  - Stimulus: start pulsed at k+1 and at k+2.
  - Response: exactly one done pulse; ir_l/pc_l unchanged; the next start after busy falls completes normally.
- Reset mid-operation:
  - Stimulus: reset asserted during EVAL.
  - Response: next cycle state IDLE, all outputs 0, no pc_load/done, counters 0.
- Counter saturation:
  - Stimulus: CNT_W=2; run 5 taken branches.
  - Response: br_cnt=3 and taken_cnt=3 after the third branch and after the fifth.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared types and field positions for the conditional-branch sequencer.
package branch_pkg;

  // Sequencer states: one cycle to evaluate the condition, one to update the PC.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    EVAL   = 2'b01,
    UPDATE = 2'b10
  } state_e;

  // Condition select codes understood by the condition evaluator.
  localparam logic [1:0] COND_ZR = 2'b00;
  localparam logic [1:0] COND_NZ = 2'b01;
  localparam logic [1:0] COND_PL = 2'b10;
  localparam logic [1:0] COND_MI = 2'b11;

  // IR field positions: C2 sits directly above the branch offset C.
  localparam int C2_HI     = 20;
  localparam int C2_LO     = 19;
  localparam int OFF_W_DEF = 19;

endpackage

// File: rtl/branch_seq_sat_counter.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Increment only while below the ceiling so the count never wraps.
  always_comb begin
    q_d = q_q;
    if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/branch_seq.sv
// Conditional-branch sequencer: asks the condition evaluator for CON,
// registers it, then strobes a PC load of PC + sign-extended offset when taken.
module branch_seq
  import branch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = OFF_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] ir,
  input  logic [DATA_W-1:0] pc,
  input  logic              con,
  output logic [1:0]        c2,
  output logic              con_en,
  output logic              con_q,
  output logic [DATA_W-1:0] pc_next,
  output logic              pc_load,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_e state_q;
  state_e state_d;

  logic [DATA_W-1:0] ir_l_q;
  logic [DATA_W-1:0] ir_l_d;
  logic [DATA_W-1:0] pc_l_q;
  logic [DATA_W-1:0] pc_l_d;
  logic              con_q_q;
  logic              con_q_d;

  logic [DATA_W-1:0] off_ext;
  logic              br_inc;
  logic              taken_inc;

  // IR bits above C2 belong to other instruction fields and are not used here.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir_l_q[DATA_W-1:C2_HI+1];

  // Next-state and strobe decode; start is only honoured from IDLE and never queued.
  always_comb begin
    state_d = state_q;
    ir_l_d  = ir_l_q;
    pc_l_d  = pc_l_q;
    con_q_d = con_q_q;
    busy    = 1'b0;
    con_en  = 1'b0;
    done    = 1'b0;
    pc_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ir_l_d  = ir;
          pc_l_d  = pc;
          state_d = EVAL;
        end
      end
      EVAL: begin
        busy    = 1'b1;
        con_en  = 1'b1;
        con_q_d = con;
        state_d = UPDATE;
      end
      UPDATE: begin
        busy    = 1'b1;
        done    = 1'b1;
        pc_load = con_q_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, instruction/PC latches and the registered CON; reset abandons any branch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      ir_l_q  <= '0;
      pc_l_q  <= '0;
      con_q_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_l_q  <= ir_l_d;
      pc_l_q  <= pc_l_d;
      con_q_q <= con_q_d;
    end
  end

  // Target is formed from the latched copies, so it stays stable between sequences.
  assign off_ext = {{(DATA_W-OFF_W){ir_l_q[OFF_W-1]}}, ir_l_q[OFF_W-1:0]};
  assign pc_next = pc_l_q + off_ext;
  assign c2      = ir_l_q[C2_HI:C2_LO];
  assign con_q   = con_q_q;

  // Statistics advance as the UPDATE cycle closes; taken can never outrun total.
  assign br_inc    = (state_q == UPDATE);
  assign taken_inc = (state_q == UPDATE) && con_q_q;

  sat_counter #(.W(CNT_W)) u_br_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (br_inc),
    .q     (br_cnt)
  );

  sat_counter #(.W(CNT_W)) u_taken_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (taken_inc),
    .q     (taken_cnt)
  );

endmodule

// File: tb/tb_branch_seq.sv
// Directed bench for branch_seq: taken/not-taken, negative offsets, busy
// rejection, mid-sequence reset and counter saturation (narrow second instance).
module tb_branch_seq;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        con;

  logic [1:0]  c2;
  logic        con_en;
  logic        con_q;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        busy;
  logic        done;
  logic [15:0] br_cnt;
  logic [15:0] taken_cnt;

  logic [1:0]  s_c2;
  logic        s_con_en;
  logic        s_con_q;
  logic [31:0] s_pc_next;
  logic        s_pc_load;
  logic        s_busy;
  logic        s_done;
  logic [1:0]  s_br_cnt;
  logic [1:0]  s_taken_cnt;

  int tests_run;
  int tests_failed;

  // Observations captured by run_branch for the calling test to compare.
  logic        ev_con_en, ev_busy;
  logic [1:0]  ev_c2;
  logic        up_done, up_load, up_con_q, up_busy;
  logic [1:0]  up_c2;
  logic [31:0] up_pc;
  logic        af_busy, af_done;

  branch_seq u_dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ir        (ir),
    .pc        (pc),
    .con       (con),
    .c2        (c2),
    .con_en    (con_en),
    .con_q     (con_q),
    .pc_next   (pc_next),
    .pc_load   (pc_load),
    .busy      (busy),
    .done      (done),
    .br_cnt    (br_cnt),
    .taken_cnt (taken_cnt)
  );

  branch_seq #(.CNT_W(2)) u_sat (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .ir        (ir),
    .pc        (pc),
    .con       (con),
    .c2        (s_c2),
    .con_en    (s_con_en),
    .con_q     (s_con_q),
    .pc_next   (s_pc_next),
    .pc_load   (s_pc_load),
    .busy      (s_busy),
    .done      (s_done),
    .br_cnt    (s_br_cnt),
    .taken_cnt (s_taken_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One full branch; entered and left at 1 time unit after a rising edge.
  // con carries the opposite value outside EVAL to show it is only sampled there.
  task automatic run_branch(input logic [31:0] pc_v, input logic [31:0] ir_v, input logic con_v);
    start = 1'b1; pc = pc_v; ir = ir_v; con = ~con_v;
    @(posedge clock); #1;
    ev_con_en = con_en; ev_c2 = c2; ev_busy = busy;
    start = 1'b0; pc = ~pc_v; ir = ~ir_v; con = con_v;
    @(posedge clock); #1;
    up_done = done; up_load = pc_load; up_pc = pc_next; up_con_q = con_q;
    up_busy = busy; up_c2 = c2;
    con = ~con_v;
    @(posedge clock); #1;
    af_busy = busy; af_done = done;
    $display("[TB] branch pc=%h ir=%h con=%b -> done=%b load=%b target=%h br=%0d taken=%0d",
             pc_v, ir_v, con_v, up_done, up_load, up_pc, br_cnt, taken_cnt);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ir = 32'hFFFF_FFFF; pc = 32'hFFFF_FFFF; con = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (con_en !== 1'b0) begin tests_failed++; $display("FAIL reset_con_en: got %b expected 0", con_en); end
    tests_run++; if (done !== 1'b0 || pc_load !== 1'b0) begin tests_failed++; $display("FAIL reset_strobes: got done=%b load=%b expected 0 0", done, pc_load); end
    tests_run++; if (c2 !== 2'b00 || con_q !== 1'b0) begin tests_failed++; $display("FAIL reset_c2_conq: got c2=%b con_q=%b expected 00 0", c2, con_q); end
    tests_run++; if (pc_next !== 32'h0) begin tests_failed++; $display("FAIL reset_pc_next: got %h expected 00000000", pc_next); end
    tests_run++; if (br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin tests_failed++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", br_cnt, taken_cnt); end
    $display("[TB] reset applied, busy=%b br=%0d taken=%0d", busy, br_cnt, taken_cnt);
  endtask

  task automatic test_taken();
    run_branch(32'h0000_0100, 32'h0000_0010, 1'b1);
    tests_run++; if (ev_con_en !== 1'b1 || ev_busy !== 1'b1) begin tests_failed++; $display("FAIL taken_eval: got con_en=%b busy=%b expected 1 1", ev_con_en, ev_busy); end
    tests_run++; if (ev_c2 !== 2'b00) begin tests_failed++; $display("FAIL taken_c2: got %b expected 00", ev_c2); end
    tests_run++; if (up_done !== 1'b1 || up_load !== 1'b1) begin tests_failed++; $display("FAIL taken_strobes: got done=%b load=%b expected 1 1", up_done, up_load); end
    tests_run++; if (up_pc !== 32'h0000_0110) begin tests_failed++; $display("FAIL taken_target: got %h expected 00000110", up_pc); end
    tests_run++; if (af_busy !== 1'b0 || af_done !== 1'b0) begin tests_failed++; $display("FAIL taken_idle: got busy=%b done=%b expected 0 0", af_busy, af_done); end
    tests_run++; if (br_cnt !== 16'd1 || taken_cnt !== 16'd1) begin tests_failed++; $display("FAIL taken_counters: got %0d/%0d expected 1/1", br_cnt, taken_cnt); end
  endtask

  task automatic test_not_taken();
    run_branch(32'h0000_0200, 32'h0008_0020, 1'b0);
    tests_run++; if (ev_c2 !== 2'b01) begin tests_failed++; $display("FAIL nt_c2: got %b expected 01", ev_c2); end
    tests_run++; if (up_done !== 1'b1 || up_load !== 1'b0) begin tests_failed++; $display("FAIL nt_strobes: got done=%b load=%b expected 1 0", up_done, up_load); end
    tests_run++; if (up_con_q !== 1'b0) begin tests_failed++; $display("FAIL nt_con_q: got %b expected 0", up_con_q); end
    tests_run++; if (con_q !== 1'b0) begin tests_failed++; $display("FAIL nt_con_q_hold: got %b expected 0", con_q); end
    tests_run++; if (br_cnt !== 16'd2 || taken_cnt !== 16'd1) begin tests_failed++; $display("FAIL nt_counters: got %0d/%0d expected 2/1", br_cnt, taken_cnt); end
  endtask

  task automatic test_neg_offset();
    run_branch(32'h0000_0004, 32'h001F_FFF8, 1'b1);
    tests_run++; if (ev_c2 !== 2'b11) begin tests_failed++; $display("FAIL neg1_c2: got %b expected 11", ev_c2); end
    tests_run++; if (up_load !== 1'b1 || up_pc !== 32'hFFFF_FFFC) begin tests_failed++; $display("FAIL neg1_target: got load=%b pc=%h expected 1 fffffffc", up_load, up_pc); end
    run_branch(32'h0000_0100, 32'h0017_FFF0, 1'b1);
    tests_run++; if (ev_c2 !== 2'b10) begin tests_failed++; $display("FAIL neg2_c2: got %b expected 10", ev_c2); end
    tests_run++; if (up_load !== 1'b1 || up_pc !== 32'h0000_00F0) begin tests_failed++; $display("FAIL neg2_target: got load=%b pc=%h expected 1 000000f0", up_load, up_pc); end
    tests_run++; if (pc_next !== 32'h0000_00F0) begin tests_failed++; $display("FAIL neg2_hold: got %h expected 000000f0", pc_next); end
    tests_run++; if (br_cnt !== 16'd4 || taken_cnt !== 16'd3) begin tests_failed++; $display("FAIL neg_counters: got %0d/%0d expected 4/3", br_cnt, taken_cnt); end
  endtask

  task automatic test_start_while_busy();
    int done_seen;
    done_seen = 0;
    start = 1'b1; pc = 32'h0000_0300; ir = 32'h0000_0004; con = 1'b0;
    @(posedge clock); #1;
    // EVAL: competing request with different IR/PC
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL busy_eval: got %b expected 1", busy); end
    start = 1'b1; pc = 32'h0000_0900; ir = 32'h0018_0040; con = 1'b1;
    @(posedge clock); #1;
    // UPDATE: another competing request
    if (done === 1'b1) done_seen++;
    tests_run++; if (pc_load !== 1'b1 || pc_next !== 32'h0000_0304) begin tests_failed++; $display("FAIL busy_target: got load=%b pc=%h expected 1 00000304", pc_load, pc_next); end
    tests_run++; if (c2 !== 2'b00) begin tests_failed++; $display("FAIL busy_c2_held: got %b expected 00", c2); end
    start = 1'b1; pc = 32'h0000_0900; ir = 32'h0018_0040; con = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL busy_not_queued: got busy=%b expected 0", busy); end
    for (int i = 0; i < 4; i++) begin
      if (done === 1'b1) done_seen++;
      @(posedge clock); #1;
    end
    tests_run++; if (done_seen !== 1) begin tests_failed++; $display("FAIL busy_done_count: got %0d expected 1", done_seen); end
    tests_run++; if (pc_next !== 32'h0000_0304) begin tests_failed++; $display("FAIL busy_latch_held: got %h expected 00000304", pc_next); end
    $display("[TB] busy test: done pulses=%0d br=%0d taken=%0d", done_seen, br_cnt, taken_cnt);
    run_branch(32'h0000_0400, 32'h0008_0008, 1'b1);
    tests_run++; if (up_done !== 1'b1 || up_load !== 1'b1 || up_pc !== 32'h0000_0408) begin tests_failed++; $display("FAIL busy_next: got done=%b load=%b pc=%h expected 1 1 00000408", up_done, up_load, up_pc); end
    tests_run++; if (br_cnt !== 16'd6 || taken_cnt !== 16'd5) begin tests_failed++; $display("FAIL busy_counters: got %0d/%0d expected 6/5", br_cnt, taken_cnt); end
  endtask

  task automatic test_reset_mid();
    int strobes;
    strobes = 0;
    start = 1'b1; pc = 32'h0000_1000; ir = 32'h0018_0100; con = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    tests_run++; if (con_en !== 1'b1) begin tests_failed++; $display("FAIL mid_in_eval: got con_en=%b expected 1", con_en); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    tests_run++; if (busy !== 1'b0 || con_en !== 1'b0 || done !== 1'b0 || pc_load !== 1'b0) begin tests_failed++; $display("FAIL mid_strobes: got busy=%b con_en=%b done=%b load=%b expected 0 0 0 0", busy, con_en, done, pc_load); end
    tests_run++; if (c2 !== 2'b00 || con_q !== 1'b0 || pc_next !== 32'h0) begin tests_failed++; $display("FAIL mid_outputs: got c2=%b con_q=%b pc=%h expected 00 0 00000000", c2, con_q, pc_next); end
    tests_run++; if (br_cnt !== 16'd0 || taken_cnt !== 16'd0) begin tests_failed++; $display("FAIL mid_counters: got %0d/%0d expected 0/0", br_cnt, taken_cnt); end
    for (int i = 0; i < 3; i++) begin
      if (done === 1'b1 || pc_load === 1'b1) strobes++;
      @(posedge clock); #1;
    end
    tests_run++; if (strobes !== 0) begin tests_failed++; $display("FAIL mid_no_strobe: got %0d strobes expected 0", strobes); end
    $display("[TB] reset mid-EVAL: busy=%b br=%0d taken=%0d", busy, br_cnt, taken_cnt);
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 5; i++) begin
      run_branch(32'h0000_0010 * i, 32'h0000_0004, 1'b1);
      if (i == 3) begin
        tests_run++; if (s_br_cnt !== 2'd3 || s_taken_cnt !== 2'd3) begin tests_failed++; $display("FAIL sat_third: got %0d/%0d expected 3/3", s_br_cnt, s_taken_cnt); end
      end
    end
    tests_run++; if (s_br_cnt !== 2'd3 || s_taken_cnt !== 2'd3) begin tests_failed++; $display("FAIL sat_fifth: got %0d/%0d expected 3/3", s_br_cnt, s_taken_cnt); end
    tests_run++; if (br_cnt !== 16'd5 || taken_cnt !== 16'd5) begin tests_failed++; $display("FAIL sat_wide: got %0d/%0d expected 5/5", br_cnt, taken_cnt); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_taken();
    test_not_taken();
    test_neg_offset();
    test_start_while_busy();
    test_reset_mid();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
